// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared encodings for the contador counter and its driver
//
// Purpose : mode encodings used on the counter mode bus, the driver FSM state
//           enum and the default load-confirmation timeout.
// Ports   : none (package).

package contador_pkg;

  // Counter mode bus encodings.
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_DN3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Driver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LWAIT = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } drv_state_e;

  // Cycles to wait for the counter's load flag before giving up (1..15).
  localparam int unsigned LOAD_TMO_DEF = 4;

endpackage

// File: rtl/contador_driver_if.sv
// rtl/contador_driver_if.sv - valid/ready command channel into contador_driver
//
// Purpose : groups the command handshake between the system sequencer
//           (master) and contador_driver (slave).
// Signals : cmd_valid  - command present
//           cmd_ready  - driver idle, command taken when valid && ready
//           cmd_op     - run mode (00 up, 01 down, 10 down-by-3, 11 illegal)
//           cmd_start  - value loaded into the counter
//           cmd_nwrap  - number of rco pulses to run, 0 = load only

interface contador_driver_if #(
  parameter int NWRAP_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [3:0]         cmd_start;
  logic [NWRAP_W-1:0] cmd_nwrap;

  modport master (
    output cmd_valid, cmd_op, cmd_start, cmd_nwrap,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_start, cmd_nwrap,
    output cmd_ready
  );
endinterface

// File: rtl/contador_ref_model.sv
// rtl/contador_ref_model.sv - combinational next-Q / wrap model of the contador counter
//
// Purpose : given the current Q and mode, returns the Q the counter holds after
//           one enabled clock and whether that step is a wrap (rco next cycle).
// Ports   : mode   in  2  counter mode
//           q      in  4  current counter value
//           d      in  4  load value for MODE_LOAD
//           q_next out 4  value after one enabled step
//           wrap   out 1  step wraps around (counter raises rco after it)

module contador_ref_model
  import contador_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] q,
  input  logic [3:0] d,
  output logic [3:0] q_next,
  output logic       wrap
);

  always_comb begin
    q_next = q;
    wrap   = 1'b0;
    case (mode)
      MODE_UP: begin
        q_next = q + 4'd1;
        wrap   = (q == 4'hF);
      end
      MODE_DOWN: begin
        q_next = q - 4'd1;
        wrap   = (q == 4'h0);
      end
      MODE_DN3: begin
        q_next = q - 4'd3;
        wrap   = (q < 4'd3);
      end
      default: begin
        q_next = d;
        wrap   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/contador_driver.sv
// rtl/contador_driver.sv - command-driven initiator for the 4-bit contador counter
//
// Purpose : accepts a command, loads the counter with mode 11, waits for the
//           counter's load flag, runs it in the requested mode for cmd_nwrap
//           rco pulses and reports done with a snapshot of Q.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           cmd            - contador_driver_if.slave command channel
//           mode, D, enable - drive to the counter
//           Q, rco, load   - status from the counter
//           done, q_final  - completion pulse and captured Q
//           err            - load timeout or illegal op pulse
//           chk_err        - only with CONTADOR_DRV_CHECK_EN: first Q mismatch
//                            against the reference model during a run
// Options : CONTADOR_DRV_CHECK_EN enables the reference-model checker.

module contador_driver
  import contador_pkg::*;
#(
  parameter int NWRAP_W  = 8,
  parameter int LOAD_TMO = LOAD_TMO_DEF
) (
  input  logic                clk,
  input  logic                reset,
  contador_driver_if.slave    cmd,
  output logic [1:0]          mode,
  output logic [3:0]          D,
  output logic                enable,
  input  logic [3:0]          Q,
  input  logic                rco,
  input  logic                load,
  output logic                done,
  output logic [3:0]          q_final,
  output logic                err
`ifdef CONTADOR_DRV_CHECK_EN
  ,
  output logic                chk_err
`endif
);

  localparam logic [3:0] TMO_LAST = 4'(LOAD_TMO - 1);

  drv_state_e         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [3:0]         start_q, start_d;
  logic [NWRAP_W-1:0] nwrap_q, nwrap_d;
  logic [NWRAP_W-1:0] wrap_q, wrap_d;
  logic [NWRAP_W-1:0] wrap_inc;
  logic [3:0]         tmo_q, tmo_d;
  logic [3:0]         q_final_q, q_final_d;
  logic               err_q, err_d;
  logic               final_wrap;

  assign wrap_inc   = wrap_q + 1'b1;
  // The rco that completes the run; enable must fall in this same cycle so
  // the counter parks on the post-wrap value.
  assign final_wrap = (state_q == ST_RUN) && rco && (wrap_inc == nwrap_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= MODE_UP;
      start_q   <= 4'd0;
      nwrap_q   <= '0;
      wrap_q    <= '0;
      tmo_q     <= 4'd0;
      q_final_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      start_q   <= start_d;
      nwrap_q   <= nwrap_d;
      wrap_q    <= wrap_d;
      tmo_q     <= tmo_d;
      q_final_q <= q_final_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    start_d   = start_q;
    nwrap_d   = nwrap_q;
    wrap_d    = wrap_q;
    tmo_d     = tmo_q;
    q_final_d = q_final_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          if (cmd.cmd_op == MODE_LOAD) begin
            err_d = 1'b1;
          end else begin
            op_d    = cmd.cmd_op;
            start_d = cmd.cmd_start;
            nwrap_d = cmd.cmd_nwrap;
            wrap_d  = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        tmo_d   = 4'd0;
        state_d = ST_LWAIT;
      end
      ST_LWAIT: begin
        if (load) begin
          state_d = (nwrap_q != '0) ? ST_RUN : ST_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (rco) begin
          wrap_d = (&wrap_q) ? wrap_q : wrap_inc;
          if (final_wrap) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        q_final_d = Q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    cmd.cmd_ready = (state_q == ST_IDLE);
    mode          = MODE_UP;
    enable        = 1'b0;
    D             = start_q;
    done          = 1'b0;
    case (state_q)
      ST_LOAD: begin
        mode   = MODE_LOAD;
        enable = 1'b1;
      end
      ST_LWAIT: mode = MODE_LOAD;
      ST_RUN: begin
        mode   = op_q;
        enable = !final_wrap;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign q_final = q_final_q;
  assign err     = err_q;

`ifdef CONTADOR_DRV_CHECK_EN
  logic [3:0] exp_q_q, exp_q_d;
  logic       exp_rco_q, exp_rco_d;
  logic       chk_seen_q, chk_seen_d;
  logic       chk_err_q, chk_err_d;
  logic [3:0] mdl_q_next;
  logic       mdl_wrap;
  logic       mismatch;

  contador_ref_model u_ref (
    .mode   (op_q),
    .q      (exp_q_q),
    .d      (start_q),
    .q_next (mdl_q_next),
    .wrap   (mdl_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q_q    <= 4'd0;
      exp_rco_q  <= 1'b0;
      chk_seen_q <= 1'b0;
      chk_err_q  <= 1'b0;
    end else begin
      exp_q_q    <= exp_q_d;
      exp_rco_q  <= exp_rco_d;
      chk_seen_q <= chk_seen_d;
      chk_err_q  <= chk_err_d;
    end
  end

  always_comb begin
    exp_q_d    = exp_q_q;
    exp_rco_d  = 1'b0;
    chk_seen_d = chk_seen_q;
    mismatch   = 1'b0;
    if (state_q == ST_LOAD) chk_seen_d = 1'b0;
    if (state_q == ST_LWAIT && load && nwrap_q != '0) begin
      // Run starts from the loaded value.
      mismatch = (Q != start_q);
      exp_q_d  = start_q;
    end
    if (state_q == ST_RUN) begin
      mismatch = (Q != exp_q_q) || (rco != exp_rco_q);
      if (enable) begin
        exp_q_d   = mdl_q_next;
        exp_rco_d = mdl_wrap;
      end
    end
    chk_err_d = mismatch && !chk_seen_q;
    if (mismatch) chk_seen_d = 1'b1;
  end

  assign chk_err = chk_err_q;
`endif

endmodule
